// File: rtl/fft16_pkg.sv
// Shared definitions for the 16-point radix-2 FFT butterfly sequencer:
// FSM states, transform size, twiddle format and address helpers.
package fft16_pkg;

    localparam int N        = 16;
    localparam int LOG2N    = 4;
    localparam int TW_WIDTH = 16;
    localparam int TW_FRAC  = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Upper operand is always addr_a + 2^s, so only the lower one is computed here.
    function automatic logic [3:0] bf_addr_a(input logic [1:0] s, input logic [2:0] b);
        logic [3:0] span;
        logic [3:0] j;
        logic [3:0] g;
        span = 4'd1 << s;
        j    = {1'b0, b} & (span - 4'd1);
        g    = {1'b0, b} >> s;
        return (g << ({1'b0, s} + 3'd1)) | j;
    endfunction

    function automatic logic [2:0] bf_twiddle_k(input logic [1:0] s, input logic [2:0] b);
        logic [2:0] j;
        j = b & ((3'd1 << s) - 3'd1);
        return j << (2'd3 - s);
    endfunction

endpackage

// File: rtl/fft16_twiddle_rom.sv
// Combinational W16^k table in Q2.14: tw_re = cos(2*pi*k/16), tw_im = -sin(2*pi*k/16).
module fft16_twiddle_rom
    import fft16_pkg::*;
(
    input  logic [2:0]          k,
    output logic [TW_WIDTH-1:0] tw_re,
    output logic [TW_WIDTH-1:0] tw_im
);

    always_comb begin
        tw_re = '0;
        tw_im = '0;
        case (k)
            3'd0: begin tw_re = 16'(16384);  tw_im = 16'(0);      end
            3'd1: begin tw_re = 16'(15137);  tw_im = 16'(-6270);  end
            3'd2: begin tw_re = 16'(11585);  tw_im = 16'(-11585); end
            3'd3: begin tw_re = 16'(6270);   tw_im = 16'(-15137); end
            3'd4: begin tw_re = 16'(0);      tw_im = 16'(-16384); end
            3'd5: begin tw_re = 16'(-6270);  tw_im = 16'(-15137); end
            3'd6: begin tw_re = 16'(-11585); tw_im = 16'(-11585); end
            3'd7: begin tw_re = 16'(-15137); tw_im = 16'(-6270);  end
            default: begin tw_re = '0; tw_im = '0; end
        endcase
    end

endmodule

// File: rtl/fft16_butterfly_sequencer.sv
// Address/twiddle sequencer for an in-place 16-point radix-2 FFT with a
// stage barrier: each stage drains its writebacks before the next one reads.
module fft16_butterfly_sequencer
    import fft16_pkg::*;
#(
    parameter int BF_LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                bf_ready,
    output logic                bf_valid,
    output logic [3:0]          rd_addr_a,
    output logic [3:0]          rd_addr_b,
    output logic [TW_WIDTH-1:0] tw_re,
    output logic [TW_WIDTH-1:0] tw_im,
    output logic                wr_en,
    output logic [3:0]          wr_addr_a,
    output logic [3:0]          wr_addr_b,
    output logic [1:0]          stage,
    output logic                busy,
    output logic                done
);

    // The entry in the last slot is writing back this cycle, so the pipeline
    // is empty at the next edge when every earlier slot is idle.
    localparam logic [BF_LATENCY-1:0] HEAD_MASK = {BF_LATENCY{1'b1}} >> 1;

    state_t                state, state_nxt;
    logic [1:0]            stage_q, stage_nxt;
    logic [2:0]            b_q, b_nxt;
    logic                  issue;
    logic [3:0]            addr_a, addr_b;
    logic [2:0]            k;
    logic [BF_LATENCY-1:0] pipe_valid;
    logic [3:0]            pipe_a [BF_LATENCY];
    logic [3:0]            pipe_b [BF_LATENCY];
    logic                  head_empty;

    assign head_empty = (pipe_valid & HEAD_MASK) == '0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            stage_q    <= 2'd0;
            b_q        <= 3'd0;
            pipe_valid <= '0;
            for (int i = 0; i < BF_LATENCY; i++) begin
                pipe_a[i] <= 4'd0;
                pipe_b[i] <= 4'd0;
            end
        end else begin
            state         <= state_nxt;
            stage_q       <= stage_nxt;
            b_q           <= b_nxt;
            pipe_valid[0] <= issue;
            pipe_a[0]     <= addr_a;
            pipe_b[0]     <= addr_b;
            for (int i = 1; i < BF_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_a[i]     <= pipe_a[i-1];
                pipe_b[i]     <= pipe_b[i-1];
            end
        end
    end

    always_comb begin
        state_nxt = state;
        stage_nxt = stage_q;
        b_nxt     = b_q;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_ISSUE;
                    stage_nxt = 2'd0;
                    b_nxt     = 3'd0;
                end
            end
            ST_ISSUE: begin
                if (bf_ready) begin
                    issue = 1'b1;
                    b_nxt = b_q + 3'd1;
                    if (b_q == 3'd7) begin
                        state_nxt = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (head_empty) begin
                    if (stage_q == 2'd3) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_ISSUE;
                        stage_nxt = stage_q + 2'd1;
                    end
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                stage_nxt = 2'd0;
                b_nxt     = 3'd0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign addr_a = bf_addr_a(stage_q, b_q);
    assign addr_b = addr_a + (4'd1 << stage_q);
    assign k      = (state == ST_ISSUE) ? bf_twiddle_k(stage_q, b_q) : 3'd0;

    assign bf_valid  = issue;
    assign rd_addr_a = (state == ST_ISSUE) ? addr_a : 4'd0;
    assign rd_addr_b = (state == ST_ISSUE) ? addr_b : 4'd0;
    assign wr_en     = pipe_valid[BF_LATENCY-1];
    assign wr_addr_a = wr_en ? pipe_a[BF_LATENCY-1] : 4'd0;
    assign wr_addr_b = wr_en ? pipe_b[BF_LATENCY-1] : 4'd0;
    assign busy      = (state == ST_ISSUE) || (state == ST_DRAIN);
    assign done      = (state == ST_DONE);
    assign stage     = busy ? stage_q : 2'd0;

    fft16_twiddle_rom u_twiddle_rom (
        .k     (k),
        .tw_re (tw_re),
        .tw_im (tw_im)
    );

endmodule
